// File: rtl/cpu_alu_pkg.sv
// Shared opcode encoding and constants for the cpu_alu datapath.
package cpu_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } alu_opcode_t;

  localparam int unsigned MAX_DATA_WIDTH = 64;

  // Sliced down to DATA_WIDTH by each user; also the reset value of the result register.
  localparam logic [MAX_DATA_WIDTH-1:0] ALU_ZERO = '0;

  function automatic logic uses_subtract(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/cpu_alu_addsub.sv
// Single shared adder for ADD/SUB; the borrow of a - b doubles as the unsigned SLT result.
module cpu_alu_addsub #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  borrow
);

  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum_ext;

  // Subtraction is a + ~b + 1; the carry-in rides on the low bit of a zero-extended term.
  always_comb begin
    b_eff   = sub ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub};
    sum     = sum_ext[DATA_WIDTH-1:0];
    borrow  = sub & ~sum_ext[DATA_WIDTH];
  end

endmodule

// File: rtl/cpu_alu.sv
// Combinational ALU with a registered copy of result and zero flag.
// Define CPU_ALU_EXT_OPS_EN to add XOR, SLL and SRL.
module cpu_alu
  import cpu_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            op_sel,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  z_flag,
  output logic [DATA_WIDTH-1:0] alu_out_q,
  output logic                  z_flag_q
);

  localparam logic [DATA_WIDTH-1:0] RESULT_ZERO = ALU_ZERO[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] addsub_sum;
  logic                  addsub_borrow;
  logic [DATA_WIDTH-1:0] alu_out_d;
  logic                  z_flag_d;

  cpu_alu_addsub #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_addsub (
    .a      (in_a),
    .b      (in_b),
    .sub    (uses_subtract(op_sel)),
    .sum    (addsub_sum),
    .borrow (addsub_borrow)
  );

`ifdef CPU_ALU_EXT_OPS_EN
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  logic [SHAMT_W-1:0] shamt;
  assign shamt = in_b[SHAMT_W-1:0];
`endif

  always_comb begin
    alu_out_d = RESULT_ZERO;
    case (alu_opcode_t'(op_sel))
      OP_ADD:  alu_out_d = addsub_sum;
      OP_SUB:  alu_out_d = addsub_sum;
      OP_AND:  alu_out_d = in_a & in_b;
      OP_OR:   alu_out_d = in_a | in_b;
      OP_SLT:  alu_out_d = {{(DATA_WIDTH-1){1'b0}}, addsub_borrow};
`ifdef CPU_ALU_EXT_OPS_EN
      OP_XOR:  alu_out_d = in_a ^ in_b;
      OP_SLL:  alu_out_d = in_a << shamt;
      OP_SRL:  alu_out_d = in_a >> shamt;
`endif
      default: alu_out_d = RESULT_ZERO;
    endcase
    z_flag_d = (alu_out_d == RESULT_ZERO);
  end

  assign alu_out = alu_out_d;
  assign z_flag  = z_flag_d;

  // Reset forces a zero result with the flag set, matching what a zero output would register.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= RESULT_ZERO;
      z_flag_q  <= 1'b1;
    end else begin
      alu_out_q <= alu_out_d;
      z_flag_q  <= z_flag_d;
    end
  end

endmodule

// File: tb/tb_cpu_alu.sv
// Self-checking bench for cpu_alu: directed corner cases followed by a random run.
module tb_cpu_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    op_sel = 3'b000;
  logic [W-1:0]  alu_out;
  logic          z_flag;
  logic [W-1:0]  alu_out_q;
  logic          z_flag_q;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_alu #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_a      (in_a),
    .in_b      (in_b),
    .op_sel    (op_sel),
    .alu_out   (alu_out),
    .z_flag    (z_flag),
    .alu_out_q (alu_out_q),
    .z_flag_q  (z_flag_q)
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned r  = 0;
    case (op)
      3'd0: r = ua + ub;
      3'd1: r = ua - ub;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd5: r = (ua < ub) ? 1 : 0;
`ifdef CPU_ALU_EXT_OPS_EN
      3'd4: r = ua ^ ub;
      3'd6: r = ua << (ub % W);
      3'd7: r = ua >> (ub % W);
`endif
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic r);
    logic [W-1:0] exp;
    rst = r; in_a = a; in_b = b; op_sel = op;
    #1;
    exp = model(a, b, op);
    check({tag, "_out"}, alu_out, exp);
    check({tag, "_z"}, z_flag, exp == '0);
    @(posedge clk);
    #1;
    check({tag, "_out_q"}, alu_out_q, r ? '0 : exp);
    check({tag, "_z_q"}, z_flag_q, r ? 1'b1 : (exp == '0));
    $display("%s rst=%0d op=%0d a=%08h b=%08h out=%08h z=%0d out_q=%08h z_q=%0d",
             tag, r, op, a, b, alu_out, z_flag, alu_out_q, z_flag_q);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    @(negedge clk);
    // Reset: registered outputs go to zero result with flag set.
    step("reset", 32'h0000_0000, 32'h0000_0000, 3'b000, 1'b1);
    step("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b0);
    step("sub_neg", 32'd5, 32'd7, 3'b001, 1'b0);
    step("sub_eq", 32'h1234, 32'h1234, 3'b001, 1'b0);
    step("slt_lt", 32'h0000_0001, 32'h8000_0000, 3'b101, 1'b0);
    step("slt_gt", 32'h8000_0000, 32'h0000_0001, 3'b101, 1'b0);
    step("slt_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b101, 1'b0);
    step("and_zero", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b010, 1'b0);
    step("or_ones", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b011, 1'b0);
    step("op100", 32'hAAAA_AAAA, 32'hFFFF_FFFF, 3'b100, 1'b0);
    step("op110", 32'h0000_0003, 32'h0000_0024, 3'b110, 1'b0);
    step("op111", 32'h8000_0000, 32'h0000_001F, 3'b111, 1'b0);
    // Mid-stream reset overrides the register but leaves the combinational path alone.
    step("rst_mid", 32'd3, 32'd4, 3'b000, 1'b1);
    step("add_3_4", 32'd3, 32'd4, 3'b000, 1'b0);
    step("sub_0_1", 32'd0, 32'd1, 3'b001, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 15) == 0) ra = '1;
      step($sformatf("rnd%0d", i), ra, rb, rop, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
